// File: rtl/rvld_pkg.sv
// Shared constants and counter-width helper for the reset-release conditioner.
package rvld_pkg;

  localparam int RVLD_STAGES_DEF = 2;
  localparam int RVLD_HOLD_DEF   = 4;
  localparam int RVLD_STAGES_MIN = 2;
  localparam int RVLD_STAGES_MAX = 8;
  localparam int RVLD_HOLD_MIN   = 0;
  localparam int RVLD_HOLD_MAX   = 255;

  // Width needed to hold 0..hold, never narrower than one bit.
  function automatic int rvld_cnt_width(input int hold);
    int w;
    w = $clog2(hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rvld_sync_chain.sv
// STAGES-deep shift register with synchronous clear; exposes every stage.
module rvld_sync_chain
  import rvld_pkg::*;
#(
  parameter int STAGES = RVLD_STAGES_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              d,
  output logic [STAGES-1:0] q_all
);

  logic [STAGES-1:0] sh_q;
  logic [STAGES-1:0] sh_d;

  always_comb begin
    sh_d = {sh_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (clr) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign q_all = sh_q;

endmodule

// File: rtl/rvld_core.sv
// Reset conditioner: synchronous assert, release after STAGES high samples and HOLD edges.
// Optional RVLD_SCAN_BYPASS_EN lets scan_mode route rstb straight to rstb_o.
module rvld_core
  import rvld_pkg::*;
#(
  parameter int STAGES = RVLD_STAGES_DEF,
  parameter int HOLD   = RVLD_HOLD_DEF
) (
  output logic rstb_o,
  input  logic rstb,
  input  logic clk,
  input  logic scan_mode
);

  if (STAGES < RVLD_STAGES_MIN || STAGES > RVLD_STAGES_MAX) begin : g_bad_stages
    $error("rvld_core: STAGES out of range 2..8");
  end
  if (HOLD < RVLD_HOLD_MIN || HOLD > RVLD_HOLD_MAX) begin : g_bad_hold
    $error("rvld_core: HOLD out of range 0..255");
  end

  localparam int            CW     = rvld_cnt_width(HOLD);
  localparam logic [CW:0]   HOLD_W = (CW+1)'(HOLD);
  localparam logic [CW-1:0] HOLD_N = CW'(HOLD);

  logic [STAGES-1:0] sh;
  logic              sh_all_next;
  logic              unused_sh_msb;
  logic [CW:0]       cnt_inc;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              o_q;
  logic              o_d;

  rvld_sync_chain #(.STAGES(STAGES)) u_sync_chain (
    .clk   (clk),
    .clr   (~rstb),
    .d     (1'b1),
    .q_all (sh)
  );

  // The shifted-in bit is always 1, so the next chain value is all ones
  // exactly when every stage but the top one is already high.
  assign sh_all_next   = &sh[STAGES-2:0];
  assign unused_sh_msb = sh[STAGES-1];

  always_comb begin
    cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
    cnt_d   = cnt_q;
    if (!o_q) begin
      cnt_d = (cnt_inc >= HOLD_W) ? HOLD_N : cnt_inc[CW-1:0];
    end
    o_d = o_q | (sh_all_next & ({1'b0, cnt_d} >= HOLD_W));
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt_q <= '0;
      o_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      o_q   <= o_d;
    end
  end

`ifdef RVLD_SCAN_BYPASS_EN
  assign rstb_o = scan_mode ? rstb : o_q;
`else
  logic unused_scan_mode;
  assign unused_scan_mode = scan_mode;
  assign rstb_o = o_q;
`endif

endmodule

// File: tb/tb_rvld_core.sv
// Directed bench for rvld_core across four STAGES/HOLD configurations.
module tb_rvld_core;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic scan_mode = 1'b0;
  logic ro_a, ro_b, ro_c, ro_d;
  int   n_chk = 0;
  int   n_err = 0;

  // Release edges counted from the last low edge, worked out by hand:
  // a: S2/H4 -> 4, b: S3/H0 -> 3, c: S2/H255 -> 255, d: S2/H1 -> 2.
  localparam int REL_A = 4;
  localparam int REL_B = 3;
  localparam int REL_C = 255;
  localparam int REL_D = 2;

  always #5 clk = ~clk;

  rvld_core #(.STAGES(2), .HOLD(4))   u_dut_a (.rstb_o(ro_a), .rstb(rstb), .clk(clk), .scan_mode(scan_mode));
  rvld_core #(.STAGES(3), .HOLD(0))   u_dut_b (.rstb_o(ro_b), .rstb(rstb), .clk(clk), .scan_mode(scan_mode));
  rvld_core #(.STAGES(2), .HOLD(255)) u_dut_c (.rstb_o(ro_c), .rstb(rstb), .clk(clk), .scan_mode(scan_mode));
  rvld_core #(.STAGES(2), .HOLD(1))   u_dut_d (.rstb_o(ro_d), .rstb(rstb), .clk(clk), .scan_mode(scan_mode));

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick(input logic r);
    @(negedge clk);
    rstb = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_a"}, ro_a, 1'b0);
    chk({tag, "_b"}, ro_b, 1'b0);
    chk({tag, "_c"}, ro_c, 1'b0);
    chk({tag, "_d"}, ro_d, 1'b0);
  endtask

  task automatic run_highs(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      tick(1'b1);
      chk($sformatf("%s_a_e%0d", tag, k), ro_a, (k >= REL_A) ? 1'b1 : 1'b0);
      chk($sformatf("%s_b_e%0d", tag, k), ro_b, (k >= REL_B) ? 1'b1 : 1'b0);
      chk($sformatf("%s_c_e%0d", tag, k), ro_c, (k >= REL_C) ? 1'b1 : 1'b0);
      chk($sformatf("%s_d_e%0d", tag, k), ro_d, (k >= REL_D) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single low edge, then long high run covering HOLD=255 saturation.
    tick(1'b0);
    chk_all_low("reset");
    run_highs("single", 260);

    // Five low edges then release.
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      chk_all_low($sformatf("long_low%0d", i));
    end
    run_highs("long", 6);

    // One-edge low pulse at high-edge 3 restarts the countdown.
    tick(1'b0);
    chk_all_low("pulse_pre");
    tick(1'b1);
    chk("pulse_h1_a", ro_a, 1'b0);
    tick(1'b1);
    chk("pulse_h2_a", ro_a, 1'b0);
    tick(1'b0);
    chk_all_low("pulse_at3");
    run_highs("pulse", 6);

    // Steady release, single low edge, 100 clean highs.
    tick(1'b0);
    chk_all_low("steady_drop");
    run_highs("steady", 100);

`ifdef RVLD_SCAN_BYPASS_EN
    scan_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rstb = (i % 2 == 0) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("scan_a_%0d", i), ro_a, (i % 2 == 0) ? 1'b0 : 1'b1);
      chk($sformatf("scan_c_%0d", i), ro_c, (i % 2 == 0) ? 1'b0 : 1'b1);
    end
    scan_mode = 1'b0;
`else
    scan_mode = 1'b1;
`endif
    tick(1'b0);
    chk_all_low("scan_func_low");
    run_highs("scan_func", 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
